music_seq_ctrl: RTL and testbench
=================================

Name: music_seq_ctrl

Overview:
- Top-level sequencer for the note datapath: turns user record/play/stop requests into the datapath's ld_note, ld_play, note_counter, display_note and next_note_en controls.
- Records up to 16 notes into the 16-entry note memory.
- Plays the stored sequence back, holding each note for a programmable duration.
- Sits between the debounced key/switch logic and the datapath; owns the recorded-note count.

Parameters:
- NOTE_CYCLES, 25000000, clk cycles each note is held during playback (must be >= 4).
- MEM_DEPTH, 16, note memory entries; note_counter width is fixed at 4.

Ports:
- clk  input  1  system clock
- reset  input  1  reset, synchronous, active-low
- record_req  input  1  level from debounced key; rising edge requests one note store
- play_req  input  1  level; rising edge starts playback
- stop_req  input  1  level; high aborts playback (sampled every cycle)
- ld_note  output  1  datapath store strobe (1-cycle pulse)
- ld_play  output  1  datapath playback-select, high for the whole playback
- note_counter  output  4  playback memory address
- display_note  output  1  1-cycle pulse when the current note's read data is valid
- next_note_en  output  1  1-cycle pulse on the last hold cycle of each note
- note_count  output  5  notes stored, 0..16
- playing  output  1  high while in any PLAY_* state
- mem_full  output  1  note_count == 16

Behaviour:
- Edge detection:
  - Internal 1-flop history on record_req and play_req; the request is the rising edge.
  - History resets to 1, so a key held through reset does not fire.
- Reset:
  - Every output is 0; state is IDLE; note_count is 0; hold counter is 0.
  - Reset asserted mid-operation returns to IDLE on the next edge and clears the count.
- States and transitions:
  - IDLE:
    - record edge and !mem_full -> REC_STROBE.
    - play edge and note_count != 0 -> PLAY_SETUP.
    - play edge with note_count == 0 is ignored.
    - Record and play edges in the same cycle: play wins; the record edge is dropped.
  - REC_STROBE: ld_note = 1 for exactly one cycle; go to REC_GAP.
  - REC_GAP:
    - ld_note = 0 for one cycle, which lets the datapath advance its write address.
    - note_count increments; go to IDLE.
    - Minimum spacing between two stores is therefore 2 cycles.
  - PLAY_SETUP: ld_play = 1; note_counter = 0; hold counter cleared; go to PLAY_HOLD.
  - PLAY_HOLD:
    - ld_play = 1; hold counter increments each cycle.
    - display_note pulses when the hold counter == 2 (registered address + synchronous RAM read latency).
    - At hold counter == NOTE_CYCLES-1: next_note_en pulses and the state goes to PLAY_NEXT.
  - PLAY_NEXT (1 cycle):
    - If note_counter == note_count-1: go to IDLE and drop ld_play on entry to IDLE.
    - Otherwise: note_counter += 1, clear the hold counter, go to PLAY_HOLD.
- Stop: stop_req high in any PLAY_* state goes to IDLE next cycle. ld_play falls, note_counter resets to 0, and no next_note_en is issued.
- Playing state rules:
  - Record edges are ignored while playing.
  - note_count is unchanged by playback.
- Full memory: a record edge with note_count == 16 is ignored; there is no wrap and no overwrite.
- Widths:
  - note_count saturates at 16 (5 bits).
  - The hold counter is $clog2(NOTE_CYCLES) bits.
  - note_counter wraps only under LOOP_PLAYBACK_EN.
- All outputs are registered; a request edge produces its first control output 1 cycle later.

Optional Feature:
- Macro: MUSIC_SEQ_LOOP_PLAYBACK_EN.
- Defined: in PLAY_NEXT, when note_counter == note_count-1, note_counter wraps to 0 and the state returns to PLAY_HOLD. Playback repeats until stop_req or reset.
- Undefined: playback stops after the last stored note, as described above.

Decomposition:
- Shared package music_pkg holds:
  - the state enum type seq_state_t (IDLE, REC_STROBE, REC_GAP, PLAY_SETUP, PLAY_HOLD, PLAY_NEXT);
  - the constants MEM_DEPTH = 16 and RD_LATENCY = 2.
- One natural sub-module: rise_detect (1-bit edge detector with reset-to-1 history), instantiated twice.

Test Plan:
- Reset with record_req held high, then release reset -> no ld_note; note_count = 0; all outputs 0.
- 3 record edges spaced 5 cycles apart -> exactly 3 one-cycle ld_note pulses, each followed by a low cycle; note_count = 3.
- 17 record edges -> 16 ld_note pulses; mem_full = 1 after the 16th; the 17th is ignored and note_count stays 16.
- NOTE_CYCLES = 8, note_count = 3, play edge:
  - ld_play is high for 3 × (8+1) + 1 cycles;
  - note_counter steps 0, 1, 2;
  - display_note pulses 3 times, at hold count 2;
  - next_note_en pulses 3 times;
  - playing then falls.
- stop_req mid-note 1 -> IDLE next cycle; ld_play = 0; note_counter = 0; no further next_note_en. A play edge with note_count = 0 -> no state change.
- With MUSIC_SEQ_LOOP_PLAYBACK_EN and note_count = 2 -> note_counter sequence 0, 1, 0, 1, … until stop_req.

Source files
------------

// File: rtl/music_pkg.sv
// Shared types and constants for the music sequencer.
package music_pkg;

  localparam int unsigned MEM_DEPTH  = 16;
  // Registered address plus synchronous RAM read.
  localparam int unsigned RD_LATENCY = 2;

  typedef enum logic [2:0] {
    StIdle,
    StRecStrobe,
    StRecGap,
    StPlaySetup,
    StPlayHold,
    StPlayNext
  } seq_state_t;

  function automatic logic is_play_state(seq_state_t s);
    return (s == StPlaySetup) || (s == StPlayHold) || (s == StPlayNext);
  endfunction

endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector with a reset-to-1 history flop, so that a level
// held high through reset does not produce an edge.
module rise_detect (
  input  logic clk,
  input  logic reset,
  input  logic sig_i,
  output logic rise_o
);

  logic hist_q, hist_d;

  // Next history is simply the current level.
  always_comb begin
    hist_d = sig_i;
  end

  // History register, synchronous active-low reset to 1.
  always_ff @(posedge clk) begin
    if (!reset) begin
      hist_q <= 1'b1;
    end else begin
      hist_q <= hist_d;
    end
  end

  assign rise_o = sig_i & ~hist_q;

endmodule

// File: rtl/music_seq_ctrl.sv
// Record/playback sequencer for the note datapath.
// Optional build macro MUSIC_SEQ_LOOP_PLAYBACK_EN: playback wraps to the first
// note after the last one and repeats until stop_req or reset.
module music_seq_ctrl
  import music_pkg::*;
#(
  parameter int unsigned NOTE_CYCLES = 25000000,
  parameter int unsigned MEM_DEPTH   = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       record_req,
  input  logic       play_req,
  input  logic       stop_req,
  output logic       ld_note,
  output logic       ld_play,
  output logic [3:0] note_counter,
  output logic       display_note,
  output logic       next_note_en,
  output logic [4:0] note_count,
  output logic       playing,
  output logic       mem_full
);

  localparam int unsigned HoldW = $clog2(NOTE_CYCLES);
  localparam logic [HoldW-1:0] HoldLast    = HoldW'(NOTE_CYCLES - 1);
  // Outputs are registered, so pulses are launched one hold count early.
  localparam logic [HoldW-1:0] HoldPreLast = HoldW'(NOTE_CYCLES - 2);
  localparam logic [HoldW-1:0] HoldPreShow = HoldW'(RD_LATENCY - 1);
  localparam logic [4:0]       CountFull   = 5'(MEM_DEPTH);

  seq_state_t       state_q, state_d;
  logic [HoldW-1:0] hold_q, hold_d;
  logic [4:0]       count_q, count_d;
  logic [3:0]       addr_q, addr_d;
  logic ld_note_q, ld_note_d, ld_play_q, ld_play_d;
  logic display_q, display_d, next_en_q, next_en_d;
  logic playing_q, playing_d, mem_full_q, mem_full_d;
  logic rec_rise, play_rise, last_note;

  rise_detect u_rec_rise (
    .clk    (clk),
    .reset  (reset),
    .sig_i  (record_req),
    .rise_o (rec_rise)
  );

  rise_detect u_play_rise (
    .clk    (clk),
    .reset  (reset),
    .sig_i  (play_req),
    .rise_o (play_rise)
  );

  assign last_note = ({1'b0, addr_q} == (count_q - 5'd1));

  // Next state and next values of all registered outputs.
  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    count_d   = count_q;
    addr_d    = addr_q;
    ld_note_d = 1'b0;
    ld_play_d = 1'b0;
    display_d = 1'b0;
    next_en_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        // Play has priority; a simultaneous record edge is dropped.
        if (play_rise && (count_q != 5'd0)) begin
          state_d   = StPlaySetup;
          ld_play_d = 1'b1;
          addr_d    = 4'd0;
          hold_d    = '0;
        end else if (rec_rise && !mem_full_q) begin
          state_d   = StRecStrobe;
          ld_note_d = 1'b1;
        end
      end
      StRecStrobe: state_d = StRecGap;
      StRecGap: begin
        state_d = StIdle;
        if (count_q != CountFull) count_d = count_q + 5'd1;
      end
      StPlaySetup: begin
        state_d   = StPlayHold;
        ld_play_d = 1'b1;
        hold_d    = '0;
      end
      StPlayHold: begin
        ld_play_d = 1'b1;
        hold_d    = hold_q + 1'b1;
        if (hold_q == HoldPreShow) display_d = 1'b1;
        if (hold_q == HoldPreLast) next_en_d = 1'b1;
        if (hold_q == HoldLast) begin
          state_d = StPlayNext;
          hold_d  = '0;
        end
      end
      StPlayNext: begin
        hold_d = '0;
        if (last_note) begin
          addr_d = 4'd0;
`ifdef MUSIC_SEQ_LOOP_PLAYBACK_EN
          state_d   = StPlayHold;
          ld_play_d = 1'b1;
`else
          state_d   = StIdle;
`endif
        end else begin
          addr_d    = addr_q + 4'd1;
          state_d   = StPlayHold;
          ld_play_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
    // Stop aborts playback immediately and suppresses any pending pulse.
    if (stop_req && is_play_state(state_q)) begin
      state_d   = StIdle;
      ld_play_d = 1'b0;
      addr_d    = 4'd0;
      hold_d    = '0;
      display_d = 1'b0;
      next_en_d = 1'b0;
    end
    playing_d  = is_play_state(state_d);
    mem_full_d = (count_d == CountFull);
  end

  // State and output registers, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= StIdle;
      hold_q     <= '0;
      count_q    <= 5'd0;
      addr_q     <= 4'd0;
      ld_note_q  <= 1'b0;
      ld_play_q  <= 1'b0;
      display_q  <= 1'b0;
      next_en_q  <= 1'b0;
      playing_q  <= 1'b0;
      mem_full_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      count_q    <= count_d;
      addr_q     <= addr_d;
      ld_note_q  <= ld_note_d;
      ld_play_q  <= ld_play_d;
      display_q  <= display_d;
      next_en_q  <= next_en_d;
      playing_q  <= playing_d;
      mem_full_q <= mem_full_d;
    end
  end

  assign ld_note      = ld_note_q;
  assign ld_play      = ld_play_q;
  assign note_counter = addr_q;
  assign display_note = display_q;
  assign next_note_en = next_en_q;
  assign note_count   = count_q;
  assign playing      = playing_q;
  assign mem_full     = mem_full_q;

endmodule

// File: tb/tb_music_seq_ctrl.sv
// Scoreboard bench for music_seq_ctrl: stimulus pushes expected output events
// (with their cycle offset inside a playback), a monitor pops and compares.
module tb_music_seq_ctrl;

  localparam int NC = 8;
`ifdef MUSIC_SEQ_LOOP_PLAYBACK_EN
  localparam bit Loop = 1'b1;
`else
  localparam bit Loop = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic record_req = 1'b0;
  logic play_req = 1'b0;
  logic stop_req = 1'b0;
  logic ld_note, ld_play, display_note, next_note_en, playing, mem_full;
  logic [3:0] note_counter;
  logic [4:0] note_count;

  always #5 clk = ~clk;

  music_seq_ctrl #(
    .NOTE_CYCLES (NC),
    .MEM_DEPTH   (16)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .record_req   (record_req),
    .play_req     (play_req),
    .stop_req     (stop_req),
    .ld_note      (ld_note),
    .ld_play      (ld_play),
    .note_counter (note_counter),
    .display_note (display_note),
    .next_note_en (next_note_en),
    .note_count   (note_count),
    .playing      (playing),
    .mem_full     (mem_full)
  );

  typedef enum logic [1:0] {EvStore, EvDisplay, EvNext, EvEnd} ev_kind_t;
  typedef struct {
    ev_kind_t kind;
    int       val;   // expected note_count / note_counter, -1 = don't care
    int       off;   // cycle offset from the first ld_play-high sample
  } ev_t;

  ev_t exp_q[$];
  int  n_checks = 0;
  int  n_pass = 0;
  int  model_count = 0;

  function automatic void check(string name, int got, int want);
    n_checks++;
    if (got == want) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, got, want);
  endfunction

  function automatic void push(ev_kind_t k, int v, int o);
    ev_t e;
    e.kind = k;
    e.val  = v;
    e.off  = o;
    exp_q.push_back(e);
  endfunction

  // Playback model: note k starts at offset 1+k*(NC+1), holds NC cycles,
  // shows its data 2 cycles in and asks for the next note on its last cycle.
  // A stop seen at offset t keeps ld_play high for offsets 0..t only.
  function automatic void push_play(bit stop, int t);
    int s;
    for (int k = 0; k < 1000; k++) begin
      s = 1 + k * (NC + 1);
      if (!Loop && k >= model_count) break;
      if (stop && s > t) break;
      if (!stop || s + 2 <= t) push(EvDisplay, k % model_count, s + 2);
      if (!stop || s + NC - 1 <= t) push(EvNext, k % model_count, s + NC - 1);
    end
    push(EvEnd, stop ? 0 : -1, stop ? t + 1 : model_count * (NC + 1) + 1);
  endfunction

  function automatic void observe(ev_kind_t k, int val, int o);
    ev_t e;
    if (exp_q.size() == 0) begin
      check({"unexpected ", k.name()}, exp_q.size(), 1);
      return;
    end
    e = exp_q.pop_front();
    check({k.name(), " event kind"}, int'(k), int'(e.kind));
    if (e.val >= 0) check({k.name(), " value"}, val, e.val);
    if (k != EvStore) check({k.name(), " offset"}, o, e.off);
  endfunction

  // Monitor: turns output pulses/edges into events for the scoreboard.
  int   off = 0;
  logic ld_play_p = 1'b0;
  always @(negedge clk) begin
    if (!reset) begin
      ld_play_p = 1'b0;
      off = 0;
    end else begin
      if (ld_play) off = ld_play_p ? off + 1 : 0;
      if (ld_note) observe(EvStore, int'(note_count), 0);
      if (display_note) begin
        observe(EvDisplay, int'(note_counter), off);
        check("playing during display", int'(playing), 1);
      end
      if (next_note_en) observe(EvNext, int'(note_counter), off);
      if (ld_play_p && !ld_play) begin
        observe(EvEnd, int'(note_counter), off + 1);
        check("playing after end", int'(playing), 0);
      end
      ld_play_p = ld_play;
    end
  end

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_record(int h, int l);
    if (model_count < 16) begin
      push(EvStore, model_count, 0);
      model_count++;
    end
    record_req = 1'b1;
    tick(h);
    record_req = 1'b0;
    tick(l);
    check("note_count after record", int'(note_count), model_count);
    check("mem_full after record", int'(mem_full), int'(model_count == 16));
  endtask

  task automatic play_empty();
    play_req = 1'b1;
    tick(1);
    play_req = 1'b0;
    tick(3);
    check("empty play ld_play", int'(ld_play), 0);
    check("empty play playing", int'(playing), 0);
    check("empty play note_count", int'(note_count), 0);
  endtask

  task automatic do_play(bit with_rec, bit stop, int t);
    int cnt;
    push_play(stop, t);
    play_req = 1'b1;
    if (with_rec) record_req = 1'b1;
    tick(1);                        // offset 0
    tick(1);                        // offset 1
    play_req = 1'b0;
    record_req = 1'b0;
    tick(1);                        // offset 2: record edge must be ignored
    record_req = 1'b1;
    tick(1);
    record_req = 1'b0;
    if (stop) begin
      tick(t - 3);                  // offset t
      stop_req = 1'b1;
      tick(1);
      stop_req = 1'b0;
    end
    cnt = 0;
    while (ld_play && cnt < 2000) begin
      tick(1);
      cnt++;
    end
    check("playback ends", int'(ld_play), 0);
    tick(2);
    check("events outstanding after play", exp_q.size(), 0);
    check("note_count unchanged by play", int'(note_count), model_count);
    exp_q.delete();
  endtask

  initial begin
    int loop_t;
    // Reset with both keys held: nothing may fire after release.
    record_req = 1'b1;
    play_req = 1'b1;
    tick(3);
    check("outputs in reset", int'({ld_note, ld_play, note_counter, display_note,
                                     next_note_en, note_count, playing, mem_full}), 0);
    reset = 1'b1;
    tick(4);
    check("held key after reset: note_count", int'(note_count), 0);
    check("held key after reset: ld_play", int'(ld_play), 0);
    record_req = 1'b0;
    play_req = 1'b0;
    tick(2);

    play_empty();
    repeat (3) do_record(2, 3);

    loop_t = $urandom_range(NC + 2, 4 * (NC + 1));
    do_play(1'b0, Loop, loop_t);
    do_play(1'b0, 1'b1, $urandom_range(NC + 2, 2 * NC));
    loop_t = $urandom_range(NC + 2, 4 * (NC + 1));
    do_play(1'b1, Loop, loop_t);

    // Fill memory and push two extra edges past full.
    repeat (15) do_record($urandom_range(1, 3), $urandom_range(2, 5));
    do_play(1'b0, 1'b1, $urandom_range(NC + 2, 2 * NC));

    // Reset in the middle of a playback.
    push_play(1'b1, 1000);
    play_req = 1'b1;
    tick(1);
    play_req = 1'b0;
    tick($urandom_range(3, 20));
    reset = 1'b0;
    tick(1);
    exp_q.delete();
    model_count = 0;
    tick(1);
    check("outputs after mid-play reset", int'({ld_note, ld_play, note_counter,
          display_note, next_note_en, note_count, playing, mem_full}), 0);
    reset = 1'b1;
    tick(2);

    play_empty();
    repeat (2) do_record($urandom_range(1, 3), $urandom_range(2, 5));
    loop_t = $urandom_range(NC + 2, 4 * (NC + 1));
    do_play(1'b0, Loop, loop_t);

    check("final events outstanding", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
